inv_cipher_stream: RTL

//  Iterative AES inverse cipher (AES-128/192/256), one round per clock, with valid/ready streaming handshakes.

---
 rtl/aes_pkg.sv | 99 +++++++++
 rtl/inv_round.sv | 17 +
 rtl/inv_cipher_stream.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// AES inverse-cipher constants, FSM encoding and GF(2^8) round helpers.
// Inverse S-box is computed as GF inverse of the inverse affine map rather than stored as a table.
package aes_pkg;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    localparam logic [1:0] MODE_128 = 2'd0;
    localparam logic [1:0] MODE_192 = 2'd1;
    localparam logic [1:0] MODE_256 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_ROUND,
        ST_LAST,
        ST_DONE
    } inv_fsm_t;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return NR_192;
            MODE_256: return NR_256;
            default:  return NR_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        localparam logic [7:0] INV_EXP = 8'hfe;
        logic [7:0] b;
        logic [7:0] r;
        logic [7:0] base;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        r    = 8'h01;
        base = b;
        for (int i = 0; i < 8; i++) begin
            if (INV_EXP[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    // Byte i of the state sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, key add, then InvMixColumns
// unless is_last_i (final round skips the column mix).
module inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rk_i,
    input  logic         is_last_i,
    output logic [127:0] state_o
);

    logic [127:0] keyed;

    assign keyed   = inv_sub_bytes(inv_shift_rows(state_i)) ^ rk_i;
    assign state_o = is_last_i ? keyed : inv_mix_columns(keyed);

endmodule

// File: rtl/inv_cipher_stream.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock; optional flush port under INV_CIPHER_FLUSH_EN.
// Latency: out_valid_o rises Nr+1 edges after the accepting edge; illegal modes go straight to DONE.
// Backpressure: in_ready_o only in IDLE; the result holds in DONE until out_ready_i.
module inv_cipher_stream
    import aes_pkg::*;
#(
    parameter int unsigned TAG_W        = 4,
    parameter logic [2:0]  MODE_MASK    = 3'b111,
    parameter bit          CLEAR_ON_POP = 1'b1
) (
    input  logic             clk_i,
    input  logic             reset_i,
`ifdef INV_CIPHER_FLUSH_EN
    input  logic             flush_i,
`endif
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [127:0]     in_data_i,
    input  logic [1:0]       in_mode_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic [3:0]       rk_idx_o,
    input  logic [127:0]     rk_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [127:0]     out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             out_err_o,
    output logic             busy_o
);

    inv_fsm_t         fsm_q, fsm_d;
    logic [127:0]     state_q, state_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [127:0]     out_data_q, out_data_d;
    logic             err_q, err_d;
    logic [3:0]       nr;
    logic             is_last;
    logic [127:0]     round_out;

    function automatic logic mode_legal(input logic [1:0] m);
        case (m)
            MODE_128: return MODE_MASK[0];
            MODE_192: return MODE_MASK[1];
            MODE_256: return MODE_MASK[2];
            default:  return 1'b0;
        endcase
    endfunction

    assign nr = nr_of(mode_q);

    inv_round u_round (
        .state_i   (state_q),
        .rk_i      (rk_i),
        .is_last_i (is_last),
        .state_o   (round_out)
    );

    always_comb begin
        fsm_d      = fsm_q;
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        mode_d     = mode_q;
        tag_d      = tag_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        rk_idx_o   = '0;
        is_last    = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = in_data_i;
                    mode_d  = in_mode_i;
                    tag_d   = in_tag_i;
                    if (mode_legal(in_mode_i)) begin
                        fsm_d = ST_ADD;
                    end else begin
                        fsm_d      = ST_DONE;
                        err_d      = 1'b1;
                        out_data_d = '0;
                    end
                end
            end
            ST_ADD: begin
                rk_idx_o = nr;
                state_d  = state_q ^ rk_i;
                rcnt_d   = nr - 4'd1;
                fsm_d    = ST_ROUND;
            end
            ST_ROUND: begin
                rk_idx_o = rcnt_q;
                state_d  = round_out;
                rcnt_d   = rcnt_q - 4'd1;
                if (rcnt_q == 4'd1) fsm_d = ST_LAST;
            end
            ST_LAST: begin
                is_last    = 1'b1;
                state_d    = round_out;
                out_data_d = round_out;
                fsm_d      = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    fsm_d = ST_IDLE;
                    err_d = 1'b0;
                    if (CLEAR_ON_POP) out_data_d = '0;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
`ifdef INV_CIPHER_FLUSH_EN
        // An in-flight block is abandoned without touching the visible result; a pending result is dropped.
        if (flush_i) begin
            if (fsm_q == ST_DONE) begin
                fsm_d = ST_IDLE;
                err_d = 1'b0;
                if (CLEAR_ON_POP) out_data_d = '0;
            end else if (fsm_q != ST_IDLE) begin
                fsm_d      = ST_IDLE;
                state_d    = '0;
                rcnt_d     = '0;
                out_data_d = out_data_q;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            rcnt_q     <= '0;
            mode_q     <= '0;
            tag_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            mode_q     <= mode_d;
            tag_q      <= tag_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign in_ready_o  = (fsm_q == ST_IDLE) && !reset_i;
    assign out_valid_o = (fsm_q == ST_DONE);
    assign out_data_o  = out_data_q;
    assign out_tag_o   = tag_q;
    assign out_err_o   = err_q;
    assign busy_o      = (fsm_q != ST_IDLE);

endmodule
